// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - OP_* encodings: op[0] = 1 divide / 0 multiply, op[1] = 1 signed.
//   - state_t: FSM states. ST_FIX exists only when MULDIV_SIGNED_EN is defined.
//   - ITER_DEFAULT: iteration count, which equals the operand width.
//   - magnitude(): conditional two's-complement negate, used both to take
//     operand magnitudes and to apply the result signs.
package muldiv_pkg;

   localparam int ITER_DEFAULT = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MULT  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
`ifdef MULDIV_SIGNED_EN
      ST_FIX  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   opa      : multiplicand (used by multiply)
//   opb      : divisor (used by divide)
//   wh, wl   : working pair in (acc_hi/acc_lo, or R/Q)
//   nh, nl   : working pair after this iteration
module muldiv_step (
   input  logic        is_div,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic [31:0] wh,
   input  logic [31:0] wl,
   output logic [31:0] nh,
   output logic [31:0] nl
);

   logic [32:0] madd;
   logic [32:0] trial;

   always_comb begin
      madd  = {1'b0, wh} + (wl[0] ? {1'b0, opa} : 33'd0);
      // Shifted remainder {R, Q[31]} is below 2*B, so bit 32 of the
      // 33-bit difference is set exactly when the trial goes negative.
      trial = {wh, wl[31]} - {1'b0, opb};
      nh    = '0;
      nl    = '0;
      if (is_div) begin
         if (!trial[32]) begin
            nh = trial[31:0];
            nl = {wl[30:0], 1'b1};
         end else begin
            nh = {wh[30:0], wl[31]};
            nl = {wl[30:0], 1'b0};
         end
      end else begin
         // Right shift of {carry, acc_hi, acc_lo}.
         nh = madd[32:1];
         nl = {madd[0], wl[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit beside the ALU in EX.
// Owns HI/LO and stalls the pipeline while an operation is in flight.
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : operation request and opcode (op[0] divide, op[1] signed)
//   abort         : flush; cancels the operation in flight, beats start
//   dataA, dataB  : multiplicand/dividend, multiplier/divisor
//   busy          : operation in flight (RUN, and FIX when present)
//   done          : one-cycle pulse, HI/LO updated on the previous edge
//   stall_req     : combinational stall request to the pipeline
//   hi, lo        : HI/LO architectural registers
// Build option: define MULDIV_SIGNED_EN to support signed MULT/DIV through
// an extra FIX state (latency 34 for all ops); otherwise op[1] is ignored
// and latency is 33.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        abort,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic        busy,
   output logic        done,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   opa, opb, wh, wl;
   logic [31:0]   nh, nl;
   logic [31:0]   ma, mb;
   logic          is_div;
   logic          accepting;

`ifdef MULDIV_SIGNED_EN
   logic        sa_in, sb_in;
   logic        neg_q, neg_r;
   logic [63:0] fix_prod;
   logic [31:0] fix_hi, fix_lo;

   assign sa_in = op[1] & dataA[31];
   assign sb_in = op[1] & dataB[31];
   assign ma    = magnitude(dataA, sa_in);
   assign mb    = magnitude(dataB, sb_in);

   // Sign restoration: product/quotient negated on differing signs,
   // remainder follows the dividend. Flags are zero for unsigned ops.
   always_comb begin
      fix_prod = neg_q ? (64'd0 - {wh, wl}) : {wh, wl};
      if (is_div) begin
         fix_hi = magnitude(wh, neg_r);
         fix_lo = magnitude(wl, neg_q);
      end else begin
         fix_hi = fix_prod[63:32];
         fix_lo = fix_prod[31:0];
      end
   end
`else
   logic unused_op1;

   assign unused_op1 = op[1];
   assign ma         = dataA;
   assign mb         = dataB;
`endif

   assign accepting = (state == ST_IDLE) || (state == ST_DONE);
   assign stall_req = busy | (start & ~abort & accepting);

   muldiv_step u_step (
      .is_div (is_div),
      .opa    (opa),
      .opb    (opb),
      .wh     (wh),
      .wl     (wl),
      .nh     (nh),
      .nl     (nl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         opa    <= '0;
         opb    <= '0;
         wh     <= '0;
         wl     <= '0;
         is_div <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`endif
      end else if (abort) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  opa    <= ma;
                  opb    <= mb;
                  is_div <= op[0];
                  // Multiply accumulator starts {0, B}; divide starts {R=0, Q=A}.
                  wh     <= '0;
                  wl     <= op[0] ? ma : mb;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
`ifdef MULDIV_SIGNED_EN
                  neg_q  <= sa_in ^ sb_in;
                  neg_r  <= sa_in;
`endif
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               wh  <= nh;
               wl  <= nl;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
`ifdef MULDIV_SIGNED_EN
                  state <= ST_FIX;
`else
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= nh;
                  lo    <= nl;
`endif
               end
            end
`ifdef MULDIV_SIGNED_EN
            ST_FIX: begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               hi    <= fix_hi;
               lo    <= fix_lo;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
